// File: rtl/jellyvl_synctimer_pkg.sv
// jellyvl_synctimer_pkg
//   Shared types and helpers for the sync-timer time base.
//   - state_t     : adjust handshake FSM state (RUN accepts, GUARD blocks)
//   - frac_width(): width of the fractional accumulator for a given denominator
package jellyvl_synctimer_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    // Holds 0..denominator-1 with one bit of headroom for the pre-wrap sum.
    function automatic int frac_width(input int denominator);
        return $clog2(denominator) + 1;
    endfunction

endpackage

// File: rtl/jellyvl_synctimer_timer_if.sv
// jellyvl_synctimer_timer_if
//   Control bus into the local time base.
//   set_time/set_valid       : absolute load, single cycle, no back-pressure
//   adjust_sign/adjust_valid : slew request (1 = retard, 0 = advance), held until accepted
//   adjust_ready             : request accepted in any cycle with valid && ready
//   master = producer (adjust loop / set event), slave = timer.
interface jellyvl_synctimer_timer_if #(
    parameter int TIMER_WIDTH = 64
);
    logic [TIMER_WIDTH-1:0] set_time;
    logic                   set_valid;
    logic                   adjust_sign;
    logic                   adjust_valid;
    logic                   adjust_ready;

    modport master (
        output set_time, set_valid, adjust_sign, adjust_valid,
        input  adjust_ready
    );

    modport slave (
        input  set_time, set_valid, adjust_sign, adjust_valid,
        output adjust_ready
    );
endinterface

// File: rtl/jellyvl_synctimer_frac_step.sv
// jellyvl_synctimer_frac_step
//   Fractional part of the NUMERATOR/DENOMINATOR step. Each enabled cycle adds
//   NUMERATOR % DENOMINATOR to frac; when the sum reaches DENOMINATOR the extra
//   whole unit is reported on carry and frac wraps.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart frac at 0 (dominates enable)
//   enable     : advance the accumulator this cycle
//   carry      : combinational, extra unit due on this cycle's step
//   frac       : registered fractional phase, 0..DENOMINATOR-1
module jellyvl_synctimer_frac_step
    import jellyvl_synctimer_pkg::*;
#(
    parameter int NUMERATOR   = 10,
    parameter int DENOMINATOR = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 enable,
    output logic                                 carry,
    output logic [frac_width(DENOMINATOR)-1:0]   frac
);
    localparam int FW = frac_width(DENOMINATOR);
    localparam logic [FW:0] STEP_FRAC = (FW+1)'(NUMERATOR % DENOMINATOR);
    localparam logic [FW:0] DEN       = (FW+1)'(DENOMINATOR);

    logic [FW:0] sum;
    logic [FW:0] sum_wrapped;

    always_comb begin
        sum         = {1'b0, frac} + STEP_FRAC;
        carry       = (sum >= DEN);
        sum_wrapped = carry ? (sum - DEN) : sum;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frac <= '0;
        end else if (enable) begin
            frac <= sum_wrapped[FW-1:0];
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// jellyvl_synctimer_timer
//   Free-running local time base. current_time advances NUMERATOR/DENOMINATOR
//   units per clk, slews +/-1 per accepted adjust, and loads set_time on a set.
//   Requires DENOMINATOR >= 1 and NUMERATOR >= DENOMINATOR.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : set_time/set_valid, adjust_sign/adjust_valid/adjust_ready
//   current_time : registered local time, wraps modulo 2^TIMER_WIDTH
//   Optional (JELLYVL_SYNCTIMER_TIMER_STATS_EN):
//   stat_adv_count / stat_ret_count : wrapping counts of accepted advance / retard
//   adjusts, cleared by reset and by a set.
module jellyvl_synctimer_timer
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH  = 64,
    parameter int NUMERATOR    = 10,
    parameter int DENOMINATOR  = 3,
    parameter int GUARD_CYCLES = 0
) (
    input  logic                        reset,
    input  logic                        clk,
    jellyvl_synctimer_timer_if.slave    bus,
    output logic [TIMER_WIDTH-1:0]      current_time
`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
    ,
    output logic [31:0]                 stat_adv_count,
    output logic [31:0]                 stat_ret_count
`endif
);
    localparam logic [TIMER_WIDTH-1:0] STEP_INT = TIMER_WIDTH'(NUMERATOR / DENOMINATOR);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    state_t                   state, state_next;
    logic [GW-1:0]            guard_cnt, guard_cnt_next;
    logic                     accept;
    logic                     carry;
    logic [TIMER_WIDTH-1:0]   adj;
    // Fractional phase is not needed by the time path; left visible for debug.
    logic [frac_width(DENOMINATOR)-1:0] frac_phase_unused;

    jellyvl_synctimer_frac_step #(
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR)
    ) u_frac_step (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.set_valid),
        .enable (!bus.set_valid),
        .carry  (carry),
        .frac   (frac_phase_unused)
    );

    // A set owns the cycle, so the adjust stays pending for a later cycle.
    assign bus.adjust_ready = (state == ST_RUN) && !bus.set_valid && !reset;
    assign accept           = bus.adjust_valid && bus.adjust_ready;
    // Sign is only looked at on acceptance, so an idle/undriven sign cannot leak in.
    assign adj = !accept ? '0 : (bus.adjust_sign ? '1 : TIMER_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            current_time <= '0;
        end else if (bus.set_valid) begin
            current_time <= bus.set_time;
        end else begin
            current_time <= current_time + STEP_INT + TIMER_WIDTH'(carry) + adj;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            guard_cnt <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        guard_cnt_next = guard_cnt;
        case (state)
            ST_RUN: begin
                if (accept && (GUARD_CYCLES > 0)) begin
                    state_next     = ST_GUARD;
                    guard_cnt_next = GW'(GUARD_CYCLES - 1);
                end
            end
            ST_GUARD: begin
                if (bus.set_valid || (guard_cnt == '0)) begin
                    state_next     = ST_RUN;
                    guard_cnt_next = '0;
                end else begin
                    guard_cnt_next = guard_cnt - 1'b1;
                end
            end
            default: begin
                state_next     = ST_RUN;
                guard_cnt_next = '0;
            end
        endcase
    end

`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || bus.set_valid) begin
            stat_adv_count <= '0;
            stat_ret_count <= '0;
        end else if (accept) begin
            if (bus.adjust_sign) stat_ret_count <= stat_ret_count + 32'd1;
            else                 stat_adv_count <= stat_adv_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// tb_jellyvl_synctimer_timer
//   Three instances: d0 defaults (10/3, no guard), d1 10/3 with GUARD_CYCLES=2,
//   d2 8-bit with unit step. The reference model tracks time as
//   base + floor(k*NUM/DEN) + net_adjust, with k = cycles since last load.
module tb_jellyvl_synctimer_timer;
    localparam int ND = 3;
    localparam int P_NUM [ND] = '{10, 10, 1};
    localparam int P_DEN [ND] = '{3, 3, 1};
    localparam int P_G   [ND] = '{0, 2, 0};
    localparam int P_W   [ND] = '{64, 64, 8};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jellyvl_synctimer_timer_if #(.TIMER_WIDTH(64)) if0 ();
    jellyvl_synctimer_timer_if #(.TIMER_WIDTH(64)) if1 ();
    jellyvl_synctimer_timer_if #(.TIMER_WIDTH(8))  if2 ();

    logic [63:0] t0, t1;
    logic [7:0]  t2;

    logic        d_set_valid [ND];
    logic [63:0] d_set_time  [ND];
    logic        d_valid     [ND];
    logic        d_sign      [ND];
    logic        rdy         [ND];
    logic [63:0] tm          [ND];

    assign if0.set_valid = d_set_valid[0]; assign if0.set_time = d_set_time[0];
    assign if0.adjust_valid = d_valid[0];  assign if0.adjust_sign = d_sign[0];
    assign if1.set_valid = d_set_valid[1]; assign if1.set_time = d_set_time[1];
    assign if1.adjust_valid = d_valid[1];  assign if1.adjust_sign = d_sign[1];
    assign if2.set_valid = d_set_valid[2]; assign if2.set_time = d_set_time[2][7:0];
    assign if2.adjust_valid = d_valid[2];  assign if2.adjust_sign = d_sign[2];
    assign rdy[0] = if0.adjust_ready; assign tm[0] = t0;
    assign rdy[1] = if1.adjust_ready; assign tm[1] = t1;
    assign rdy[2] = if2.adjust_ready; assign tm[2] = {56'd0, t2};

`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
    logic [31:0] sa [ND];
    logic [31:0] sr [ND];
`endif

    jellyvl_synctimer_timer #(.TIMER_WIDTH(64), .NUMERATOR(10), .DENOMINATOR(3), .GUARD_CYCLES(0)) dut0 (
        .reset(reset), .clk(clk), .bus(if0), .current_time(t0)
`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
        , .stat_adv_count(sa[0]), .stat_ret_count(sr[0])
`endif
    );
    jellyvl_synctimer_timer #(.TIMER_WIDTH(64), .NUMERATOR(10), .DENOMINATOR(3), .GUARD_CYCLES(2)) dut1 (
        .reset(reset), .clk(clk), .bus(if1), .current_time(t1)
`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
        , .stat_adv_count(sa[1]), .stat_ret_count(sr[1])
`endif
    );
    jellyvl_synctimer_timer #(.TIMER_WIDTH(8), .NUMERATOR(1), .DENOMINATOR(1), .GUARD_CYCLES(0)) dut2 (
        .reset(reset), .clk(clk), .bus(if2), .current_time(t2)
`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
        , .stat_adv_count(sa[2]), .stat_ret_count(sr[2])
`endif
    );

    // reference model
    logic [63:0] m_base [ND];
    logic [63:0] m_adj  [ND];
    longint      m_k    [ND];
    int          m_cool [ND];  // cycles still blocked after an acceptance
    int unsigned m_adv  [ND];
    int unsigned m_ret  [ND];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [63:0] exp_time(input int d);
        logic [63:0] t;
        t = m_base[d] + 64'((m_k[d] * P_NUM[d]) / P_DEN[d]) + m_adj[d];
        if (P_W[d] < 64) t = t & ((64'd1 << P_W[d]) - 64'd1);
        return t;
    endfunction

    function automatic logic exp_ready(input int d);
        return !reset && !d_set_valid[d] && (m_cool[d] == 0);
    endfunction

    // One clock edge; the model consumes the inputs as they stood before the edge.
    task automatic tick();
        logic acc [ND];
        logic rs;
        rs = reset;
        for (int d = 0; d < ND; d++) acc[d] = exp_ready(d) && d_valid[d];
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            if (rs || d_set_valid[d]) begin
                m_base[d] = rs ? 64'd0 : d_set_time[d];
                m_k[d] = 0; m_adj[d] = 64'd0; m_cool[d] = 0; m_adv[d] = 0; m_ret[d] = 0;
            end else begin
                m_k[d]++;
                if (acc[d]) begin
                    m_adj[d] = m_adj[d] + (d_sign[d] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
                    if (d_sign[d]) m_ret[d]++; else m_adv[d]++;
                    m_cool[d] = P_G[d];
                end else if (m_cool[d] > 0) begin
                    m_cool[d]--;
                end
            end
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < ND; d++) begin
            d_set_valid[d] = 1'b0; d_set_time[d] = 64'd0; d_valid[d] = 1'b0; d_sign[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_all(); #1;
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (rdy[d] !== 1'b0) $display("FAIL reset_ready d%0d got %b expected 0", d, rdy[d]); else n_pass++;
        end
        tick(); tick();
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (tm[d] !== 64'd0) $display("FAIL reset_time d%0d got %h expected 0", d, tm[d]); else n_pass++;
        end
        reset = 1'b0; #1;
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (rdy[d] !== 1'b1) $display("FAIL ready_after_reset d%0d got %b expected 1", d, rdy[d]); else n_pass++;
        end
    endtask

    task automatic test_nominal();
        logic [63:0] seq [6];
        seq = '{64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20};
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (tm[0] !== seq[i]) $display("FAIL nominal[%0d] got %0d expected %0d", i, tm[0], seq[i]); else n_pass++;
        end
    endtask

    task automatic test_set();
        logic [63:0] seq [4];
        seq = '{64'h1000, 64'h1003, 64'h1006, 64'h100A};
        d_set_time[0] = 64'h1000; d_set_valid[0] = 1'b1; #1;
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL set_ready got %b expected 0", rdy[0]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick(); d_set_valid[0] = 1'b0;
            n_chk++; if (tm[0] !== seq[i]) $display("FAIL set[%0d] got %h expected %h", i, tm[0], seq[i]); else n_pass++;
        end
    endtask

    task automatic test_adjust();
        reset = 1'b1; tick(); reset = 1'b0; tick();  // time 3
        for (int s = 0; s < 2; s++) begin
            d_valid[0] = 1'b1; d_sign[0] = s[0];
            for (int i = 0; i < 2; i++) begin
                #1;
                n_chk++; if (rdy[0] !== 1'b1) $display("FAIL adjust_ready s%0d got %b expected 1", s, rdy[0]); else n_pass++;
                tick();
                n_chk++; if (tm[0] !== exp_time(0)) $display("FAIL adjust s%0d[%0d] got %0d expected %0d", s, i, tm[0], exp_time(0)); else n_pass++;
            end
            // idle with an undriven sign: must not reach the time
            d_valid[0] = 1'b0; d_sign[0] = 1'bx;
            for (int i = 0; i < 3; i++) begin
                tick();
                n_chk++; if (tm[0] !== exp_time(0)) $display("FAIL adjust_idle s%0d[%0d] got %h expected %h", s, i, tm[0], exp_time(0)); else n_pass++;
            end
        end
        d_sign[0] = 1'b0;
    endtask

    task automatic test_guard();
        logic pat [9];
        int acc_n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        acc_n = 0;
        d_valid[1] = 1'b1; d_sign[1] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 9; i++) begin
            #1;
            n_chk++; if (rdy[1] !== pat[i]) $display("FAIL guard_ready[%0d] got %b expected %b", i, rdy[1], pat[i]); else n_pass++;
            if (rdy[1] === 1'b1) acc_n++;
            tick();
            n_chk++; if (tm[1] !== exp_time(1)) $display("FAIL guard_time[%0d] got %0d expected %0d", i, tm[1], exp_time(1)); else n_pass++;
        end
        n_chk++; if (acc_n !== 3) $display("FAIL guard_accepts got %0d expected 3", acc_n); else n_pass++;
        // accept, then a set while guarding must reopen the handshake
        tick();
        d_set_time[1] = 64'h55; d_set_valid[1] = 1'b1; tick(); d_set_valid[1] = 1'b0; #1;
        n_chk++; if (rdy[1] !== 1'b1) $display("FAIL guard_set_release got %b expected 1", rdy[1]); else n_pass++;
        // accept again, then reset while guarding discards the guard
        tick();
        reset = 1'b1; tick(); reset = 1'b0; #1;
        n_chk++; if (rdy[1] !== 1'b1) $display("FAIL guard_reset_release got %b expected 1", rdy[1]); else n_pass++;
        n_chk++; if (tm[1] !== 64'd0) $display("FAIL guard_reset_time got %h expected 0", tm[1]); else n_pass++;
        d_valid[1] = 1'b0;
    endtask

    task automatic test_collision();
        logic [63:0] st;
        st = {$urandom, $urandom};
        d_set_time[0] = st; d_set_valid[0] = 1'b1; d_valid[0] = 1'b1; d_sign[0] = 1'b0; #1;
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL collide_ready got %b expected 0", rdy[0]); else n_pass++;
        tick(); d_set_valid[0] = 1'b0;
        n_chk++; if (tm[0] !== st) $display("FAIL collide_set got %h expected %h", tm[0], st); else n_pass++;
        #1;
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL collide_pending got %b expected 1", rdy[0]); else n_pass++;
        tick(); d_valid[0] = 1'b0;
        n_chk++; if (tm[0] !== st + 64'd4) $display("FAIL collide_adjust got %h expected %h", tm[0], st + 64'd4); else n_pass++;
    endtask

    task automatic test_wrap();
        d_set_time[2] = 64'hFF; d_set_valid[2] = 1'b1; tick(); d_set_valid[2] = 1'b0;
        n_chk++; if (tm[2] !== 64'hFF) $display("FAIL wrap_set got %h expected ff", tm[2]); else n_pass++;
        d_valid[2] = 1'b1; d_sign[2] = 1'b0; tick();
        n_chk++; if (tm[2] !== 64'h01) $display("FAIL wrap_adv got %h expected 01", tm[2]); else n_pass++;
        d_sign[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (tm[2] !== 64'h01) $display("FAIL wrap_hold[%0d] got %h expected 01", i, tm[2]); else n_pass++;
        end
        d_valid[2] = 1'b0; tick();
        n_chk++; if (tm[2] !== 64'h02) $display("FAIL wrap_resume got %h expected 02", tm[2]); else n_pass++;
    endtask

    task automatic test_random();
        logic acc [ND];
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < ND; d++) begin
                if (!d_valid[d] && $urandom_range(0, 2) == 0) begin
                    d_valid[d] = 1'b1; d_sign[d] = 1'($urandom_range(0, 1));
                end else if (!d_valid[d]) begin
                    d_sign[d] = 1'($urandom_range(0, 1));
                end
                d_set_valid[d] = ($urandom_range(0, 15) == 0);
                d_set_time[d]  = {$urandom, $urandom};
            end
            #1;
            for (int d = 0; d < ND; d++) begin
                n_chk++; if (rdy[d] !== exp_ready(d)) $display("FAIL rand_ready c%0d d%0d got %b expected %b", c, d, rdy[d], exp_ready(d)); else n_pass++;
                acc[d] = exp_ready(d) && d_valid[d];
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                n_chk++; if (tm[d] !== exp_time(d)) $display("FAIL rand_time c%0d d%0d got %h expected %h", c, d, tm[d], exp_time(d)); else n_pass++;
`ifdef JELLYVL_SYNCTIMER_TIMER_STATS_EN
                n_chk++; if (sa[d] !== m_adv[d] || sr[d] !== m_ret[d])
                    $display("FAIL rand_stats c%0d d%0d got %0d/%0d expected %0d/%0d", c, d, sa[d], sr[d], m_adv[d], m_ret[d]);
                else n_pass++;
`endif
                if (acc[d]) d_valid[d] = 1'b0;
            end
        end
        reset = 1'b0;
        idle_all();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_set();
        test_adjust();
        test_guard();
        test_collision();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
